crossbar_cmd_gen_seq: RTL
=========================

Name: crossbar_cmd_gen_seq

Overview:
Command generator at the control end of the one-hot sequential crossbar. It accepts a frame of (destination, source) routing entries over a valid/ready config interface and builds them into a shadow table. When the datapath signals it is safe to swap, it commits the frame as a registered one-hot command bus that drives the crossbar's command input, together with the crossbar enable.

Parameters:
NUM_INPUT_DATA, 128, number of crossbar inputs (sources)
NUM_OUTPUT_DATA, 16, number of crossbar outputs (destinations); power of 2
SRC_WIDTH, 7, width of source index; must satisfy 2^SRC_WIDTH >= NUM_INPUT_DATA
DST_WIDTH, 4, log2(NUM_OUTPUT_DATA)

Ports:
CLK  input  1  clock
rst  input  1  asynchronous, active-low reset
cfg_valid  input  1  config beat valid
cfg_ready  output  1  config beat accepted when cfg_valid && cfg_ready
cfg_dst  input  DST_WIDTH  destination (output) index
cfg_src  input  SRC_WIDTH  source (input) index routed to cfg_dst
cfg_route_en  input  1  1 = route cfg_src to cfg_dst; 0 = disconnect cfg_dst
cfg_last  input  1  last beat of frame
i_swap_ok  input  1  datapath drained; committing is allowed this cycle
o_cmd  output  NUM_INPUT_DATA*NUM_OUTPUT_DATA  one-hot command; bit src*NUM_OUTPUT_DATA+dst = route src->dst
o_en  output  1  crossbar enable; set after the first commit
o_cmd_update  output  1  one-cycle pulse when new o_cmd first appears
o_err  output  1  sticky error: out-of-range source seen in the current frame

Behaviour:
- Reset (rst=0, async): state IDLE; shadow table cleared (all entries disabled); o_cmd=0, o_en=0, o_cmd_update=0, o_err=0; cfg_ready=0 while rst is asserted.
- Table: per destination d, shadow_en[d] (1 bit) and shadow_src[d] (SRC_WIDTH bits).
- FSM states:
  - IDLE:
    - cfg_ready=1.
    - On an accepted beat: clear the whole shadow table and clear o_err, then apply the beat on top of the cleared table (the beat wins).
    - Go to PEND if cfg_last=1, else LOAD.
  - LOAD:
    - cfg_ready=1.
    - Each accepted beat writes shadow[cfg_dst]. Repeated dst in a frame: last write wins.
    - An accepted beat with cfg_last=1 goes to PEND.
  - PEND:
    - cfg_ready=0.
    - Stays at least one cycle.
    - If i_swap_ok=1 in a PEND cycle, go to APPLY next cycle; otherwise hold indefinitely.
  - APPLY (one cycle):
    - cfg_ready=0.
    - At the closing edge: o_cmd <= decode(shadow), o_cmd_update <= 1, o_en <= 1.
    - Next state is IDLE.
- Beat write rule:
  - If cfg_src >= NUM_INPUT_DATA and cfg_route_en=1: the entry is not written and o_err is set.
  - If cfg_route_en=0: shadow_en[cfg_dst]=0; cfg_src is ignored and no error is raised.
- Decode: o_cmd[s*NUM_OUTPUT_DATA+d] = shadow_en[d] && (shadow_src[d]==s).
  - At most one bit is set per destination column.
  - One source may feed several destinations (multicast).
- o_cmd_update:
  - Set only at the APPLY edge; low otherwise.
  - Cleared at the next edge.
- o_cmd holds its value between commits; loading a new frame never disturbs the active o_cmd.
- o_err holds until the next frame's first accepted beat or reset.
- o_en never deasserts except on reset.
- Latency: last beat accepted in cycle t with i_swap_ok=1 at t+1 -> APPLY at t+2 -> new o_cmd and o_cmd_update=1 visible in cycle t+3.
- Simultaneous events:
  - i_swap_ok is ignored outside PEND.
  - cfg_valid is ignored while cfg_ready=0.
- Reset mid-operation (any state, including APPLY): everything returns to reset values immediately. A partially loaded frame is discarded.

Test Plan:
- Reset then idle: rst low 3 cycles, release -> o_cmd=0, o_en=0, o_cmd_update=0, cfg_ready=1.
- Single-beat frame: dst=3, src=5, en=1, last=1; i_swap_ok=1 -> exactly 3 cycles after acceptance o_cmd has only bit 83 set; o_cmd_update pulses 1 cycle; o_en=1.
- Multi-beat with overwrite:
  - Beats (0,10), (1,10), (0,127,last); then swap -> o_cmd bits 127*16+0=2032 and 10*16+1=161 set, all others 0 (multicast plus last-wins).
- Swap gating:
  - Frame loaded, i_swap_ok held 0 for 20 cycles -> cfg_ready=0 and the old o_cmd is unchanged throughout.
  - Raise i_swap_ok -> new o_cmd 2 cycles later.
- Error path: use NUM_INPUT_DATA=100; beat (2,120,en=1,last) -> o_err=1 and after commit column 2 is empty; the next frame's first beat clears o_err.
- Disconnect and reset mid-load:
  - Active route (4,7); new frame beat (4,x,en=0,last), commit -> bit 116 cleared.
  - Assert rst during LOAD -> o_cmd=0 immediately, state IDLE.

Source files
------------

// File: rtl/crossbar_cmd_gen_seq_if.sv
// Config channel of the crossbar command generator: one (dst, src) routing beat per transfer.
// Ports: cfg_valid/cfg_ready handshake, cfg_dst, cfg_src, cfg_route_en, cfg_last.
// Backpressure: a beat transfers only on a cycle where cfg_valid && cfg_ready.
interface crossbar_cmd_gen_seq_if #(
   parameter int SRC_WIDTH = 7,
   parameter int DST_WIDTH = 4
);
   logic                 cfg_valid;
   logic                 cfg_ready;
   logic [DST_WIDTH-1:0] cfg_dst;
   logic [SRC_WIDTH-1:0] cfg_src;
   logic                 cfg_route_en;
   logic                 cfg_last;

   modport master (
      output cfg_valid, cfg_dst, cfg_src, cfg_route_en, cfg_last,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid, cfg_dst, cfg_src, cfg_route_en, cfg_last,
      output cfg_ready
   );
endinterface

// File: rtl/crossbar_cmd_gen_seq.sv
// Builds a shadow routing table from config beats and commits it as a one-hot crossbar command.
// Latency: last beat at t, i_swap_ok at t+1 -> new o_cmd with o_cmd_update pulse visible at t+3.
// Backpressure: cfg_ready drops from the last beat until the commit, and stays low while in reset.
// Ports: CLK, rst (async active-low), cfg (slave modport), i_swap_ok, o_cmd, o_en, o_cmd_update, o_err.
module crossbar_cmd_gen_seq #(
   parameter int NUM_INPUT_DATA  = 128,
   parameter int NUM_OUTPUT_DATA = 16,
   parameter int SRC_WIDTH       = 7,
   parameter int DST_WIDTH       = 4
) (
   input  logic                                      CLK,
   input  logic                                      rst,
   crossbar_cmd_gen_seq_if.slave                     cfg,
   input  logic                                      i_swap_ok,
   output logic [NUM_INPUT_DATA*NUM_OUTPUT_DATA-1:0] o_cmd,
   output logic                                      o_en,
   output logic                                      o_cmd_update,
   output logic                                      o_err
);

   localparam int CMD_W = NUM_INPUT_DATA * NUM_OUTPUT_DATA;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_PEND  = 2'd2,
      S_APPLY = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic                 cfg_ready_q, cfg_ready_d;
   logic [NUM_OUTPUT_DATA-1:0] shadow_en_q, shadow_en_d;
   logic [SRC_WIDTH-1:0] shadow_src_q [NUM_OUTPUT_DATA];
   logic [SRC_WIDTH-1:0] shadow_src_d [NUM_OUTPUT_DATA];
   logic [CMD_W-1:0]     cmd_q, cmd_d;
   logic                 en_q, en_d;
   logic                 upd_q, upd_d;
   logic                 err_q, err_d;

   logic                 beat_acc;
   logic                 src_oob;
   logic [31:0]          src_ext;
   logic [CMD_W-1:0]     cmd_dec;

   // cfg_ready is registered so it is low throughout reset and only rises after the first edge.
   assign beat_acc = cfg.cfg_valid && cfg_ready_q;
   assign src_ext  = {{(32-SRC_WIDTH){1'b0}}, cfg.cfg_src};
   assign src_oob  = (src_ext >= 32'(NUM_INPUT_DATA));

   // One-hot decode of the shadow table: column d carries at most one bit, rows may repeat (multicast).
   always_comb begin
      cmd_dec = '0;
      for (int s = 0; s < NUM_INPUT_DATA; s++) begin
         for (int d = 0; d < NUM_OUTPUT_DATA; d++) begin
            cmd_dec[s*NUM_OUTPUT_DATA + d] = shadow_en_q[d] && (shadow_src_q[d] == SRC_WIDTH'(s));
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      shadow_en_d  = shadow_en_q;
      shadow_src_d = shadow_src_q;
      cmd_d        = cmd_q;
      en_d         = en_q;
      upd_d        = 1'b0;
      err_d        = err_q;

      // A beat can only be accepted in IDLE or LOAD, since cfg_ready tracks those states.
      if (beat_acc) begin
         if (state_q == S_IDLE) begin
            // First beat of a frame starts from an empty table and a clean error flag.
            shadow_en_d = '0;
            err_d       = 1'b0;
         end
         if (!cfg.cfg_route_en) begin
            shadow_en_d[cfg.cfg_dst] = 1'b0;
         end else if (src_oob) begin
            err_d = 1'b1;
         end else begin
            shadow_en_d[cfg.cfg_dst]  = 1'b1;
            shadow_src_d[cfg.cfg_dst] = cfg.cfg_src;
         end
         state_d = cfg.cfg_last ? S_PEND : S_LOAD;
      end

      case (state_q)
         S_PEND: begin
            if (i_swap_ok) begin
               state_d = S_APPLY;
            end
         end
         S_APPLY: begin
            cmd_d   = cmd_dec;
            upd_d   = 1'b1;
            en_d    = 1'b1;
            state_d = S_IDLE;
         end
         default: ;
      endcase

      cfg_ready_d = (state_d == S_IDLE) || (state_d == S_LOAD);
   end

   always_ff @(posedge CLK or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         cfg_ready_q <= 1'b0;
         shadow_en_q <= '0;
         for (int d = 0; d < NUM_OUTPUT_DATA; d++) begin
            shadow_src_q[d] <= '0;
         end
         cmd_q <= '0;
         en_q  <= 1'b0;
         upd_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cfg_ready_q  <= cfg_ready_d;
         shadow_en_q  <= shadow_en_d;
         shadow_src_q <= shadow_src_d;
         cmd_q        <= cmd_d;
         en_q         <= en_d;
         upd_q        <= upd_d;
         err_q        <= err_d;
      end
   end

   assign cfg.cfg_ready = cfg_ready_q;
   assign o_cmd         = cmd_q;
   assign o_en          = en_q;
   assign o_cmd_update  = upd_q;
   assign o_err         = err_q;

endmodule
